// File: rtl/serial_bus_pkg.sv
// Shared types and defaults for the serial bus slave side.
// Command encodings, receive-port states and parameter defaults.
package serial_bus_pkg;

  localparam int SLAVE_ADDR_SIZE_D = 12;
  localparam int WORD_SIZE_D = 8;
  localparam int BURST_SIZE_D = 15;

  localparam logic [1:0] CMD_READ = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_B_READ = 2'b10;
  localparam logic [1:0] CMD_B_WRITE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_DATA,
    S_RD_REQ
  } state_t;

endpackage

// File: rtl/serial_deser.sv
// LSB-first serial-to-parallel shifter with bit counter.
// word already includes the bit strobed in this cycle.
module serial_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             strobe,
  input  logic             din,
  output logic [WIDTH-1:0] word,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_nxt;
  logic [CW-1:0]    cnt;

  assign sh_nxt = {din, sh_q[WIDTH-1:1]};
  assign word = strobe ? sh_nxt : sh_q;
  assign last_bit = strobe && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
      cnt  <= '0;
    end else if (clr) begin
      sh_q <= '0;
      cnt  <= '0;
    end else if (strobe) begin
      sh_q <= sh_nxt;
      cnt  <= last_bit ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/slave_in_port.sv
// Slave-side receive port: deserializes address, length and data,
// then issues memory writes or a read request for the slave.
module slave_in_port
  import serial_bus_pkg::*;
#(
  parameter int SLAVE_ADDR_SIZE = SLAVE_ADDR_SIZE_D,
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int BURST_SIZE = BURST_SIZE_D
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sel,
  input  logic [1:0]                 cmd,
  input  logic                       addr_valid,
  input  logic                       addr_bit,
  input  logic                       burst_valid,
  input  logic                       burst_bit,
  input  logic                       data_valid,
  input  logic                       data_bit,
  input  logic                       mem_busy,
  output logic                       s_ready,
  output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic                       mem_we,
  output logic                       rd_req,
  output logic [BURST_SIZE-1:0]      rd_len,
  output logic                       wr_done,
  output logic                       abort
);

  state_t state, state_nxt;

  logic [1:0]                 cmd_q;
  logic                       armed;
  logic [SLAVE_ADDR_SIZE-1:0] aword;
  logic [BURST_SIZE-1:0]      bword;
  logic [WORD_SIZE-1:0]       dword;
  logic [BURST_SIZE-1:0]      widx;
  logic [BURST_SIZE-1:0]      len_eff;
  logic a_last, b_last, d_last;
  logic a_stb, b_stb, d_stb;
  logic active, drop, start, clr;
  logic last_word, rd_go;

  always_comb begin
    unique case (state)
      S_IDLE:   s_ready = 1'b1;
      S_RD_REQ: s_ready = 1'b0;
      default:  s_ready = !mem_busy;
    endcase
  end

  assign active = state inside {S_ADDR, S_BURST, S_DATA};
  assign drop = active && !sel;
  assign start = (state == S_IDLE) && sel && armed;
  assign clr = (state == S_IDLE);

  assign a_stb = (state == S_ADDR) && sel && addr_valid && s_ready;
  assign b_stb = (state == S_BURST) && sel && burst_valid && s_ready;
  assign d_stb = (state == S_DATA) && sel && data_valid && s_ready;

  // A zero burst length still moves one word.
  always_comb begin
    len_eff = BURST_SIZE'(1);
    if (cmd_q[1] && bword != '0) len_eff = bword;
  end

  assign last_word = (widx + 1'b1) == len_eff;
  assign rd_go = (a_last && cmd_q == CMD_READ)
              || (b_last && cmd_q == CMD_B_READ);

  serial_deser #(.WIDTH(SLAVE_ADDR_SIZE)) u_addr (
    .clk(clk), .rst_n(rst_n), .clr(clr), .strobe(a_stb),
    .din(addr_bit), .word(aword), .last_bit(a_last)
  );

  serial_deser #(.WIDTH(BURST_SIZE)) u_burst (
    .clk(clk), .rst_n(rst_n), .clr(clr), .strobe(b_stb),
    .din(burst_bit), .word(bword), .last_bit(b_last)
  );

  serial_deser #(.WIDTH(WORD_SIZE)) u_data (
    .clk(clk), .rst_n(rst_n), .clr(clr), .strobe(d_stb),
    .din(data_bit), .word(dword), .last_bit(d_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_ADDR;
      S_ADDR: begin
        if (drop) state_nxt = S_IDLE;
        else if (a_last) begin
          if (cmd_q[1]) state_nxt = S_BURST;
          else if (cmd_q[0]) state_nxt = S_DATA;
          else state_nxt = S_RD_REQ;
        end
      end
      S_BURST: begin
        if (drop) state_nxt = S_IDLE;
        else if (b_last)
          state_nxt = cmd_q[0] ? S_DATA : S_RD_REQ;
      end
      S_DATA: begin
        if (drop) state_nxt = S_IDLE;
        else if (d_last && last_word) state_nxt = S_IDLE;
      end
      S_RD_REQ: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // sel must go low once before another transaction may start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b1;
      cmd_q <= CMD_READ;
    end else begin
      if (!sel) armed <= 1'b1;
      else if (start) armed <= 1'b0;
      if (start) cmd_q <= cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rd_req    <= 1'b0;
      rd_len    <= '0;
      wr_done   <= 1'b0;
      abort     <= 1'b0;
      widx      <= '0;
    end else begin
      mem_we  <= 1'b0;
      rd_req  <= 1'b0;
      wr_done <= 1'b0;
      abort   <= drop;
      if (clr) widx <= '0;
      if (d_last) begin
        mem_we    <= 1'b1;
        mem_wdata <= dword;
        mem_addr  <= aword + SLAVE_ADDR_SIZE'(widx);
        wr_done   <= last_word;
        widx      <= widx + 1'b1;
      end
      if (rd_go) begin
        rd_req   <= 1'b1;
        mem_addr <= aword;
        rd_len   <= len_eff;
      end
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// Randomized bench for slave_in_port with a transaction-level model.
// Expected pulses are queued per cycle and checked on the falling edge.
module tb_slave_in_port;
  import serial_bus_pkg::*;

  localparam int AW = 12;
  localparam int WW = 8;
  localparam int BW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic addr_valid = 1'b0, addr_bit = 1'b0;
  logic burst_valid = 1'b0, burst_bit = 1'b0;
  logic data_valid = 1'b0, data_bit = 1'b0;
  logic mem_busy = 1'b0;
  logic s_ready;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic mem_we, rd_req, wr_done, abort;
  logic [BW-1:0] rd_len;

  slave_in_port #(
    .SLAVE_ADDR_SIZE(AW), .WORD_SIZE(WW), .BURST_SIZE(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .cmd(cmd),
    .addr_valid(addr_valid), .addr_bit(addr_bit),
    .burst_valid(burst_valid), .burst_bit(burst_bit),
    .data_valid(data_valid), .data_bit(data_bit),
    .mem_busy(mem_busy), .s_ready(s_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .rd_req(rd_req), .rd_len(rd_len),
    .wr_done(wr_done), .abort(abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] len;
    logic        done;
  } ev_t;

  ev_t q[$];
  logic [AW-1:0] we_addr_log[$];
  logic [WW-1:0] we_data_log[$];
  logic [BW-1:0] rd_len_log[$];
  int abort_cnt = 0;
  int done_cnt = 0;

  task automatic push_ev(input int kind, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] l,
                         input logic dn);
    ev_t e;
    e.cyc = cyc;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    e.len = l;
    e.done = dn;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : cmp
    ev_t e;
    if (rst_n) begin
      if (mem_we) begin
        we_addr_log.push_back(mem_addr);
        we_data_log.push_back(mem_wdata);
      end
      if (rd_req) rd_len_log.push_back(rd_len);
      if (abort) abort_cnt++;
      if (wr_done) done_cnt++;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        if (e.kind == 1) begin
          chk("mem_we", 32'(mem_we), 32'd1);
          chk("we_addr", 32'(mem_addr), e.addr);
          chk("we_data", 32'(mem_wdata), e.data);
          chk("wr_done", 32'(wr_done), 32'(e.done));
          chk("we_side", 32'({rd_req, abort}), 32'd0);
        end else if (e.kind == 2) begin
          chk("rd_req", 32'(rd_req), 32'd1);
          chk("rd_addr", 32'(mem_addr), e.addr);
          chk("rd_len", 32'(rd_len), e.len);
          chk("rd_side", 32'({mem_we, wr_done, abort}), 32'd0);
        end else begin
          chk("abort", 32'(abort), 32'd1);
          chk("abort_side", 32'({mem_we, wr_done, rd_req}), 32'd0);
        end
      end else begin
        chk("no_pulse", 32'({mem_we, rd_req, wr_done, abort}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    addr_valid = 1'b0;
    burst_valid = 1'b0;
    data_valid = 1'b0;
    mem_busy = 1'b0;
  endtask

  // phase 0 addr, 1 burst, 2 data; bp forces that many busy cycles.
  task automatic drive_bits(input int phase, input logic [31:0] val,
                            input int n, input int bp);
    int cnt = 0;
    int guard = 0;
    int bpl = bp;
    logic v, b, bv;
    while (cnt < n) begin
      if (bpl > 0 && cnt >= 3) begin
        b = 1'b1;
        v = 1'b1;
        bpl--;
      end else begin
        b = ($urandom_range(0, 4) == 0);
        v = ($urandom_range(0, 3) != 0);
      end
      bv = (v && !b) ? val[cnt] : 1'($urandom);
      addr_valid = (phase == 0) ? v : 1'($urandom);
      burst_valid = (phase == 1) ? v : 1'($urandom);
      data_valid = (phase == 2) ? v : 1'($urandom);
      addr_bit = (phase == 0) ? bv : 1'($urandom);
      burst_bit = (phase == 1) ? bv : 1'($urandom);
      data_bit = (phase == 2) ? bv : 1'($urandom);
      mem_busy = b;
      #1;
      chk("s_ready", 32'(s_ready), 32'(!b));
      tick();
      if (v && !b) cnt++;
      guard++;
      if (guard > 3000) begin
        $display("FAIL drive_bits: no progress, got %0d expected %0d",
                 cnt, n);
        $fatal(1);
      end
    end
    clear_strobes();
  endtask

  task automatic run_txn(input logic [1:0] c, input logic [AW-1:0] a,
                         input logic [BW-1:0] lf, input logic [WW-1:0] wd[8],
                         input int ab_word, input int ab_bits,
                         input int bp, input bit hold);
    int eff;
    logic [AW-1:0] wa;
    eff = (c[1] && lf != 0) ? int'(lf) : 1;
    clear_strobes();
    sel = 1'b1;
    cmd = c;
    tick();
    drive_bits(0, 32'(a), AW, 0);
    if (c[1]) drive_bits(1, 32'(lf), BW, 0);
    if (!c[0]) begin
      push_ev(2, 32'(a), 0, 32'(eff), 1'b0);
      if ($urandom_range(0, 1) == 1) sel = 1'b0;
      #1;
      chk("rd_ready", 32'(s_ready), 32'd0);
      tick();
    end else begin
      for (int w = 0; w < eff; w++) begin
        if (w == ab_word) begin
          drive_bits(2, 32'(wd[w]), ab_bits, 0);
          sel = 1'b0;
          tick();
          push_ev(3, 0, 0, 0, 1'b0);
          break;
        end
        drive_bits(2, 32'(wd[w]), WW, (w == 0) ? bp : 0);
        wa = a + AW'(w);
        push_ev(1, 32'(wa), 32'(wd[w]), 0, (w == eff - 1));
      end
    end
    if (sel && hold) begin
      for (int i = 0; i < 3; i++) begin
        addr_valid = 1'($urandom);
        data_valid = 1'($urandom);
        burst_valid = 1'($urandom);
        mem_busy = 1'($urandom);
        #1;
        chk("idle_ready", 32'(s_ready), 32'd1);
        tick();
      end
      clear_strobes();
    end
    sel = 1'b0;
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [WW-1:0] wd[8];
    logic [1:0] c;
    logic [AW-1:0] a;
    logic [BW-1:0] lf;
    int eff, abw, abb, n0;

    foreach (wd[i]) wd[i] = '0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_pulses", 32'({mem_we, rd_req, wr_done, abort}), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_len", 32'(rd_len), 32'd0);
    rst_n = 1'b1;
    tick();

    we_addr_log.delete();
    we_data_log.delete();
    wd[0] = 8'h3C;
    run_txn(CMD_WRITE, 12'h2A5, 0, wd, -1, 0, 0, 1'b1);
    chk("lit_sw_cnt", 32'(we_addr_log.size()), 32'd1);
    chk("lit_sw_addr", 32'(we_addr_log[0]), 32'h2A5);
    chk("lit_sw_data", 32'(we_data_log[0]), 32'h3C);

    we_addr_log.delete();
    we_data_log.delete();
    n0 = done_cnt;
    wd[0] = 8'h11;
    wd[1] = 8'h22;
    wd[2] = 8'h33;
    run_txn(CMD_B_WRITE, 12'hFFE, 15'd3, wd, -1, 0, 0, 1'b0);
    chk("lit_bw_cnt", 32'(we_addr_log.size()), 32'd3);
    chk("lit_bw_a0", 32'(we_addr_log[0]), 32'hFFE);
    chk("lit_bw_a1", 32'(we_addr_log[1]), 32'hFFF);
    chk("lit_bw_a2", 32'(we_addr_log[2]), 32'h000);
    chk("lit_bw_d2", 32'(we_data_log[2]), 32'h33);
    chk("lit_bw_done", 32'(done_cnt - n0), 32'd1);

    rd_len_log.delete();
    we_addr_log.delete();
    run_txn(CMD_B_READ, 12'h100, 15'd0, wd, -1, 0, 0, 1'b0);
    chk("lit_br_cnt", 32'(rd_len_log.size()), 32'd1);
    chk("lit_br_len", 32'(rd_len_log[0]), 32'd1);
    chk("lit_br_nowe", 32'(we_addr_log.size()), 32'd0);

    we_data_log.delete();
    wd[0] = 8'h5A;
    run_txn(CMD_WRITE, 12'h010, 0, wd, -1, 0, 4, 1'b0);
    chk("lit_bp_data", 32'(we_data_log[0]), 32'h5A);

    we_addr_log.delete();
    n0 = abort_cnt;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) wd[i] = 8'(8'hA0 + i);
    run_txn(CMD_B_WRITE, 12'h300, 15'd4, wd, 1, 5, 0, 1'b0);
    chk("lit_ab_cnt", 32'(we_addr_log.size()), 32'd1);
    chk("lit_ab_pulse", 32'(abort_cnt - n0), 32'd1);
    chk("lit_ab_nodone", 32'(done_cnt), 32'd0);

    sel = 1'b1;
    cmd = CMD_WRITE;
    tick();
    drive_bits(0, 32'h5C3, 5, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pulses", 32'({mem_we, rd_req, wr_done, abort}), 32'd0);
    chk("mid_rst_out", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("mid_rst_len", 32'(rd_len), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd1);
    sel = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    we_addr_log.delete();
    wd[0] = 8'hE7;
    run_txn(CMD_WRITE, 12'h7A1, 0, wd, -1, 0, 0, 1'b0);
    chk("lit_post_rst", 32'(we_addr_log.size()), 32'd1);

    for (int t = 0; t < 40; t++) begin
      c = 2'($urandom);
      a = AW'($urandom);
      lf = BW'($urandom_range(0, 5));
      foreach (wd[i]) wd[i] = WW'($urandom);
      eff = (c[1] && lf != 0) ? int'(lf) : 1;
      abw = -1;
      abb = 0;
      if (c[0] && $urandom_range(0, 4) == 0) begin
        abw = $urandom_range(0, eff - 1);
        abb = $urandom_range(0, WW - 1);
      end
      run_txn(c, a, lf, wd, abw, abb,
              ($urandom_range(0, 3) == 0) ? 4 : 0,
              1'($urandom));
    end

    tick();
    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
